// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - tile sequencer for the corelet MAC array
//
// Walks one tile through weight load, kernel load, activation load, execute,
// drain and output read for each of num_kij kernel positions, issuing memory
// reads and the 35-bit corelet instruction word.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   start               begin a run (only looked at in IDLE)
//   mode                datapath select, latched at start
//   num_kij             kernel positions per run, 0..15
//   w_base, a_base      weight / activation region base addresses
//   mem_rd, mem_addr    registered memory read strobe and address
//   mem_dout            read data, valid one cycle after mem_rd
//   inst                registered corelet instruction word
//   coreletIn           pass-through of mem_dout
//   busy, done          not-IDLE flag, one-cycle completion pulse

module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int len_nij = 36,
    parameter int addr_w  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [3:0]          num_kij,
    input  logic [addr_w-1:0]   w_base,
    input  logic [addr_w-1:0]   a_base,
    output logic                mem_rd,
    output logic [addr_w-1:0]   mem_addr,
    input  logic [bw*row-1:0]   mem_dout,
    output logic [34:0]         inst,
    output logic [bw*row-1:0]   coreletIn,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WLOAD  = 4'd1;
    localparam logic [3:0] S_KLOAD  = 4'd2;
    localparam logic [3:0] S_KFLUSH = 4'd3;
    localparam logic [3:0] S_ALOAD  = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_DRAIN  = 4'd6;
    localparam logic [3:0] S_READ   = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    // Phase counter must hold the longest state duration minus one.
    localparam int M_RC    = (row > col) ? row : col;
    localparam int M_LD    = (len_nij > row + col) ? len_nij : row + col;
    localparam int MAX_DUR = (M_RC > M_LD) ? M_RC : M_LD;
    localparam int PH_W    = $clog2(MAX_DUR + 1);

    localparam logic [PH_W-1:0]   LAST_ROW   = PH_W'(row - 1);
    localparam logic [PH_W-1:0]   LAST_COL   = PH_W'(col - 1);
    localparam logic [PH_W-1:0]   LAST_LEN   = PH_W'(len_nij - 1);
    localparam logic [PH_W-1:0]   LAST_DRAIN = PH_W'(row + col - 1);
    localparam logic [addr_w-1:0] ROW_A      = addr_w'(row);
    localparam logic [addr_w-1:0] LEN_A      = addr_w'(len_nij);

    logic [3:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [3:0]        kij_q, kij_d;
    logic [3:0]        num_q, num_d;
    logic              mode_q, mode_d;
    logic [addr_w-1:0] wb_q, wb_d;
    logic [addr_w-1:0] ab_q, ab_d;

    logic              mem_rd_q, mem_rd_d;
    logic [addr_w-1:0] mem_addr_q, mem_addr_d;
    logic [34:0]       inst_q, inst_d;

    logic [PH_W-1:0]   last_ph;
    logic [addr_w-1:0] kij_ext;
    logic [addr_w-1:0] ph_ext;

    always_comb begin
        last_ph = '0;
        case (state_q)
            S_WLOAD, S_KLOAD:  last_ph = LAST_ROW;
            S_KFLUSH:          last_ph = LAST_COL;
            S_ALOAD, S_EXEC,
            S_READ:            last_ph = LAST_LEN;
            S_DRAIN:           last_ph = LAST_DRAIN;
            default:           last_ph = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        kij_d   = kij_q;
        num_d   = num_q;
        mode_d  = mode_q;
        wb_d    = wb_q;
        ab_d    = ab_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (start) begin
                    num_d   = num_kij;
                    mode_d  = mode;
                    wb_d    = w_base;
                    ab_d    = a_base;
                    kij_d   = '0;
                    state_d = (num_kij == 4'd0) ? S_DONE : S_WLOAD;
                end
            end
            S_NEXT: begin
                phase_d = '0;
                kij_d   = kij_q + 4'd1;
                state_d = (kij_d == num_q) ? S_DONE : S_WLOAD;
            end
            S_DONE: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                if (phase_q == last_ph) begin
                    phase_d = '0;
                    case (state_q)
                        S_WLOAD:  state_d = S_KLOAD;
                        S_KLOAD:  state_d = S_KFLUSH;
                        S_KFLUSH: state_d = S_ALOAD;
                        S_ALOAD:  state_d = S_EXEC;
                        S_EXEC:   state_d = S_DRAIN;
                        S_DRAIN:  state_d = S_READ;
                        S_READ:   state_d = S_NEXT;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // state they belong to rather than trailing it by a cycle.
    always_comb begin
        kij_ext    = addr_w'(kij_d);
        ph_ext     = addr_w'(phase_d);
        mem_rd_d   = (state_d == S_WLOAD) || (state_d == S_ALOAD);
        mem_addr_d = '0;
        if (state_d == S_WLOAD)
            mem_addr_d = wb_d + kij_ext * ROW_A + ph_ext;
        else if (state_d == S_ALOAD)
            mem_addr_d = ab_d + kij_ext * LEN_A + ph_ext;

        inst_d     = '0;
        inst_d[0]  = (state_d == S_KLOAD);
        inst_d[1]  = (state_d == S_EXEC);
        inst_d[2]  = mem_rd_q;              // L0 write lands with valid mem_dout
        inst_d[3]  = (state_d == S_KLOAD) || (state_d == S_EXEC);
        inst_d[6]  = (state_d == S_READ);
        inst_d[33] = inst_q[6];             // OFIFO data arrives one cycle after read
        inst_d[34] = (state_d != S_IDLE) && mode_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            kij_q      <= '0;
            num_q      <= '0;
            mode_q     <= 1'b0;
            wb_q       <= '0;
            ab_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            kij_q      <= kij_d;
            num_q      <= num_d;
            mode_q     <= mode_d;
            wb_q       <= wb_d;
            ab_q       <= ab_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            inst_q     <= inst_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign inst      = inst_q;
    assign coreletIn = mem_dout;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
